// File: rtl/cpu_ctrl_pkg.sv
// Shared state/op-class types, opcode and ALU-select encodings, and the
// decode helpers used by the control sequencer.
package cpu_ctrl_pkg;

    localparam int OPW  = 5;
    localparam int RSW  = 4;
    localparam int ALUW = 4;
    localparam int NREG = 1 << RSW;

    typedef enum logic [3:0] {
        RST,
        T0,
        T1,
        T2,
        T3,
        T4,
        T5,
        T6,
        STOPPED,
        HALTED
    } state_e;

    typedef enum logic [2:0] {
        CLS_BIN,
        CLS_UNARY,
        CLS_MULDIV,
        CLS_NOP,
        CLS_HALT,
        CLS_ILLEGAL
    } opclass_e;

    localparam logic [OPW-1:0] OP_ADD  = 5'b00000;
    localparam logic [OPW-1:0] OP_SUB  = 5'b00001;
    localparam logic [OPW-1:0] OP_AND  = 5'b00010;
    localparam logic [OPW-1:0] OP_OR   = 5'b00011;
    localparam logic [OPW-1:0] OP_SHR  = 5'b00100;
    localparam logic [OPW-1:0] OP_SHL  = 5'b00101;
    localparam logic [OPW-1:0] OP_ROR  = 5'b00110;
    localparam logic [OPW-1:0] OP_ROL  = 5'b00111;
    localparam logic [OPW-1:0] OP_MUL  = 5'b01000;
    localparam logic [OPW-1:0] OP_DIV  = 5'b01001;
    localparam logic [OPW-1:0] OP_NEG  = 5'b01010;
    localparam logic [OPW-1:0] OP_NOT  = 5'b01011;
    localparam logic [OPW-1:0] OP_NOP  = 5'b11000;
    localparam logic [OPW-1:0] OP_HALT = 5'b11001;

    localparam logic [ALUW-1:0] ALU_ADD = 4'b0000;
    localparam logic [ALUW-1:0] ALU_SUB = 4'b0001;
    localparam logic [ALUW-1:0] ALU_MUL = 4'b0010;
    localparam logic [ALUW-1:0] ALU_DIV = 4'b0011;
    localparam logic [ALUW-1:0] ALU_AND = 4'b0100;
    localparam logic [ALUW-1:0] ALU_OR  = 4'b0101;
    localparam logic [ALUW-1:0] ALU_SHR = 4'b0110;
    localparam logic [ALUW-1:0] ALU_SHL = 4'b0111;
    localparam logic [ALUW-1:0] ALU_ROR = 4'b1000;
    localparam logic [ALUW-1:0] ALU_ROL = 4'b1001;
    localparam logic [ALUW-1:0] ALU_NEG = 4'b1010;
    localparam logic [ALUW-1:0] ALU_NOT = 4'b1011;

    // Opcodes without an ALU meaning fall back to ADD; they never reach a
    // state where the select is driven.
    function automatic logic [ALUW-1:0] op_to_alu(input logic [OPW-1:0] opcode);
        logic [ALUW-1:0] sel;
        sel = ALU_ADD;
        case (opcode)
            OP_ADD:  sel = ALU_ADD;
            OP_SUB:  sel = ALU_SUB;
            OP_AND:  sel = ALU_AND;
            OP_OR:   sel = ALU_OR;
            OP_SHR:  sel = ALU_SHR;
            OP_SHL:  sel = ALU_SHL;
            OP_ROR:  sel = ALU_ROR;
            OP_ROL:  sel = ALU_ROL;
            OP_MUL:  sel = ALU_MUL;
            OP_DIV:  sel = ALU_DIV;
            OP_NEG:  sel = ALU_NEG;
            OP_NOT:  sel = ALU_NOT;
            default: sel = ALU_ADD;
        endcase
        return sel;
    endfunction

    function automatic opclass_e op_class(input logic [OPW-1:0] opcode);
        opclass_e cls;
        cls = CLS_ILLEGAL;
        case (opcode)
            OP_ADD, OP_SUB, OP_AND, OP_OR,
            OP_SHR, OP_SHL, OP_ROR, OP_ROL: cls = CLS_BIN;
            OP_MUL, OP_DIV:                 cls = CLS_MULDIV;
            OP_NEG, OP_NOT:                 cls = CLS_UNARY;
            OP_NOP:                         cls = CLS_NOP;
            OP_HALT:                        cls = CLS_HALT;
            default:                        cls = CLS_ILLEGAL;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/reg_select_decoder.sv
// One-hot register select: turns a 4-bit register field into a 16-bit
// strobe, all zeros when not enabled.
module reg_select_decoder
    import cpu_ctrl_pkg::*;
(
    input  logic [RSW-1:0]  field_i,
    input  logic            en_i,
    output logic [NREG-1:0] onehot_o
);

    // Single set bit at the field index while enabled.
    always_comb begin
        onehot_o = '0;
        if (en_i) begin
            onehot_o[field_i] = 1'b1;
        end
    end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired Moore control unit for the shared-bus datapath: fetch (T0-T2),
// decode in T3 straight from IR, execute T4-T6 from fields latched in T3.
module control_sequencer
    import cpu_ctrl_pkg::*;
(
    input  logic            Clock,
    input  logic            clear,
    input  logic [31:0]     IR,
    input  logic            Mem_ready,
    input  logic            Stop,
    output logic            PCout,
    output logic            Zlowout,
    output logic            Zhighout,
    output logic            HIout,
    output logic            LOout,
    output logic            MDRout,
    output logic [NREG-1:0] Rout,
    output logic [NREG-1:0] Rin,
    output logic            MARin,
    output logic            PCin,
    output logic            MDRin,
    output logic            IRin,
    output logic            Yin,
    output logic            HIin,
    output logic            LOin,
    output logic            Zin_low,
    output logic            Zin_high,
    output logic            IncPC,
    output logic            Read,
    output logic [ALUW-1:0] operation,
    output logic            Run,
    output logic            Illegal
);

    state_e          state_q, state_d;
    logic [OPW-1:0]  opcode_q;
    logic [RSW-1:0]  ra_q, rb_q, rc_q;

    logic [OPW-1:0]  irOp;
    logic [RSW-1:0]  irRa, irRb, irRc;
    logic [14:0]     unusedIrBits;
    opclass_e        irClass, execClass;
    state_e          endState;

    logic [RSW-1:0]  routField, rinField;
    logic            routEn, rinEn;

    assign irOp         = IR[31:27];
    assign irRa         = IR[26:23];
    assign irRb         = IR[22:19];
    assign irRc         = IR[18:15];
    assign unusedIrBits = IR[14:0];

    assign irClass   = op_class(irOp);
    assign execClass = op_class(opcode_q);

    // Stop is only looked at when leaving the last execute state.
    assign endState = Stop ? STOPPED : T0;

    // State register; clear aborts any instruction immediately.
    always_ff @(posedge Clock or posedge clear) begin
        if (clear) begin
            state_q <= RST;
        end else begin
            state_q <= state_d;
        end
    end

    // Capture the instruction fields during decode so execute does not depend on IR afterwards.
    always_ff @(posedge Clock or posedge clear) begin
        if (clear) begin
            opcode_q <= '0;
            ra_q     <= '0;
            rb_q     <= '0;
            rc_q     <= '0;
        end else if (state_q == T3) begin
            opcode_q <= irOp;
            ra_q     <= irRa;
            rb_q     <= irRb;
            rc_q     <= irRc;
        end
    end

    // Next-state and control outputs; every output idles low unless its state drives it.
    always_comb begin
        state_d   = state_q;
        PCout     = 1'b0;
        Zlowout   = 1'b0;
        Zhighout  = 1'b0;
        HIout     = 1'b0;
        LOout     = 1'b0;
        MDRout    = 1'b0;
        MARin     = 1'b0;
        PCin      = 1'b0;
        MDRin     = 1'b0;
        IRin      = 1'b0;
        Yin       = 1'b0;
        HIin      = 1'b0;
        LOin      = 1'b0;
        Zin_low   = 1'b0;
        Zin_high  = 1'b0;
        IncPC     = 1'b0;
        Read      = 1'b0;
        operation = ALU_ADD;
        Run       = 1'b0;
        Illegal   = 1'b0;
        routField = '0;
        routEn    = 1'b0;
        rinField  = '0;
        rinEn     = 1'b0;

        case (state_q)
            RST: begin
                state_d = T0;
            end
            T0: begin
                Run       = 1'b1;
                PCout     = 1'b1;
                MARin     = 1'b1;
                IncPC     = 1'b1;
                Zin_low   = 1'b1;
                operation = ALU_ADD;
                state_d   = T1;
            end
            T1: begin
                Run     = 1'b1;
                Zlowout = 1'b1;
                Read    = 1'b1;
                MDRin   = 1'b1;
                PCin    = Mem_ready;
                if (Mem_ready) begin
                    state_d = T2;
                end
            end
            T2: begin
                Run     = 1'b1;
                MDRout  = 1'b1;
                IRin    = 1'b1;
                state_d = T3;
            end
            T3: begin
                Run     = 1'b1;
                state_d = (irClass == CLS_HALT) ? HALTED : T4;
                case (irClass)
                    CLS_BIN: begin
                        routEn    = 1'b1;
                        routField = irRb;
                        Yin       = 1'b1;
                    end
                    CLS_MULDIV: begin
                        routEn    = 1'b1;
                        routField = irRa;
                        Yin       = 1'b1;
                    end
                    CLS_ILLEGAL: begin
                        Illegal = 1'b1;
                    end
                    default: begin
                    end
                endcase
            end
            T4: begin
                Run = 1'b1;
                case (execClass)
                    CLS_BIN, CLS_MULDIV: begin
                        routEn    = 1'b1;
                        routField = (execClass == CLS_BIN) ? rc_q : rb_q;
                        operation = op_to_alu(opcode_q);
                        Zin_low   = 1'b1;
                        Zin_high  = 1'b1;
                        state_d   = T5;
                    end
                    CLS_UNARY: begin
                        routEn    = 1'b1;
                        routField = rb_q;
                        operation = op_to_alu(opcode_q);
                        Zin_low   = 1'b1;
                        state_d   = T5;
                    end
                    default: begin
                        state_d = endState;
                    end
                endcase
            end
            T5: begin
                Run     = 1'b1;
                Zlowout = 1'b1;
                if (execClass == CLS_MULDIV) begin
                    LOin    = 1'b1;
                    state_d = T6;
                end else begin
                    rinEn    = 1'b1;
                    rinField = ra_q;
                    state_d  = endState;
                end
            end
            T6: begin
                Run      = 1'b1;
                Zhighout = 1'b1;
                HIin     = 1'b1;
                state_d  = endState;
            end
            STOPPED: begin
                if (!Stop) begin
                    state_d = T0;
                end
            end
            HALTED: begin
                state_d = HALTED;
            end
            default: begin
                state_d = RST;
            end
        endcase
    end

    reg_select_decoder uRoutDecoder (
        .field_i  (routField),
        .en_i     (routEn),
        .onehot_o (Rout)
    );

    reg_select_decoder uRinDecoder (
        .field_i  (rinField),
        .en_i     (rinEn),
        .onehot_o (Rin)
    );

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: walks each instruction class through
// fetch/decode/execute and compares every control output cycle by cycle.
module tb_control_sequencer;

    logic        Clock = 1'b0;
    logic        clear;
    logic [31:0] IR;
    logic        Mem_ready;
    logic        Stop;
    logic        PCout, Zlowout, Zhighout, HIout, LOout, MDRout;
    logic [15:0] Rout, Rin;
    logic        MARin, PCin, MDRin, IRin, Yin, HIin, LOin;
    logic        Zin_low, Zin_high, IncPC, Read;
    logic [3:0]  operation;
    logic        Run, Illegal;

    int errorCount = 0;
    int checkCount = 0;

    localparam logic [18:0] M_PCOUT    = 19'h40000;
    localparam logic [18:0] M_ZLOWOUT  = 19'h20000;
    localparam logic [18:0] M_ZHIGHOUT = 19'h10000;
    localparam logic [18:0] M_MDROUT   = 19'h02000;
    localparam logic [18:0] M_MARIN    = 19'h01000;
    localparam logic [18:0] M_PCIN     = 19'h00800;
    localparam logic [18:0] M_MDRIN    = 19'h00400;
    localparam logic [18:0] M_IRIN     = 19'h00200;
    localparam logic [18:0] M_YIN      = 19'h00100;
    localparam logic [18:0] M_HIIN     = 19'h00080;
    localparam logic [18:0] M_LOIN     = 19'h00040;
    localparam logic [18:0] M_ZINL     = 19'h00020;
    localparam logic [18:0] M_ZINH     = 19'h00010;
    localparam logic [18:0] M_INCPC    = 19'h00008;
    localparam logic [18:0] M_READ     = 19'h00004;
    localparam logic [18:0] M_RUN      = 19'h00002;
    localparam logic [18:0] M_ILLEGAL  = 19'h00001;

    typedef struct packed {
        logic [18:0] ctrl;
        logic [15:0] rout;
        logic [15:0] rin;
        logic [3:0]  op;
    } exp_t;

    typedef struct {
        logic ready;
        logic stop;
        exp_t e;
    } step_t;

    localparam exp_t E_IDLE = '0;
    localparam exp_t E_T0   = {M_PCOUT | M_MARIN | M_INCPC | M_ZINL | M_RUN, 16'h0, 16'h0, 4'h0};
    localparam exp_t E_T1   = {M_ZLOWOUT | M_PCIN | M_READ | M_MDRIN | M_RUN, 16'h0, 16'h0, 4'h0};
    localparam exp_t E_T1W  = {M_ZLOWOUT | M_READ | M_MDRIN | M_RUN, 16'h0, 16'h0, 4'h0};
    localparam exp_t E_T2   = {M_MDROUT | M_IRIN | M_RUN, 16'h0, 16'h0, 4'h0};
    localparam exp_t E_RUN  = {M_RUN, 16'h0, 16'h0, 4'h0};

    logic [18:0] ctrlObs;
    exp_t        obs;

    assign ctrlObs = {PCout, Zlowout, Zhighout, HIout, LOout, MDRout, MARin, PCin, MDRin,
                      IRin, Yin, HIin, LOin, Zin_low, Zin_high, IncPC, Read, Run, Illegal};
    assign obs     = {ctrlObs, Rout, Rin, operation};

    control_sequencer dut (
        .Clock     (Clock),
        .clear     (clear),
        .IR        (IR),
        .Mem_ready (Mem_ready),
        .Stop      (Stop),
        .PCout     (PCout),
        .Zlowout   (Zlowout),
        .Zhighout  (Zhighout),
        .HIout     (HIout),
        .LOout     (LOout),
        .MDRout    (MDRout),
        .Rout      (Rout),
        .Rin       (Rin),
        .MARin     (MARin),
        .PCin      (PCin),
        .MDRin     (MDRin),
        .IRin      (IRin),
        .Yin       (Yin),
        .HIin      (HIin),
        .LOin      (LOin),
        .Zin_low   (Zin_low),
        .Zin_high  (Zin_high),
        .IncPC     (IncPC),
        .Read      (Read),
        .operation (operation),
        .Run       (Run),
        .Illegal   (Illegal)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    always #5 Clock = ~Clock;

    function automatic exp_t mk(input logic [18:0] c, input logic [15:0] ro,
                                input logic [15:0] ri, input logic [3:0] o);
        return {c, ro, ri, o};
    endfunction

    function automatic step_t st(input logic r, input logic s, input exp_t e);
        step_t x;
        x.ready = r;
        x.stop  = s;
        x.e     = e;
        return x;
    endfunction

    // Pulse clear across one edge and return just after the first edge that lands in T0.
    task automatic doReset;
        clear = 1'b1;
        @(posedge Clock); #1;
        clear = 1'b0;
        @(posedge Clock); #1;
    endtask

    task automatic test_reset;
        IR = 32'h0; Mem_ready = 1'b1; Stop = 1'b0; clear = 1'b1;
        repeat (2) @(posedge Clock);
        #1;
        checkCount++;
        if (obs !== E_IDLE) begin
            errorCount++;
            $display("[TB] FAIL reset_outputs: got ctrl=%05h rout=%04h rin=%04h op=%h, required all zero", obs.ctrl, obs.rout, obs.rin, obs.op);
        end
        clear = 1'b0;
        #1;
        checkCount++;
        if (obs !== E_IDLE) begin
            errorCount++;
            $display("[TB] FAIL reset_hold_before_edge: got ctrl=%05h, required 00000", obs.ctrl);
        end
        @(posedge Clock); #1;
        checkCount++;
        if (obs !== E_T0) begin
            errorCount++;
            $display("[TB] FAIL reset_first_t0: got ctrl=%05h op=%h, required ctrl=%05h op=%h", obs.ctrl, obs.op, E_T0.ctrl, E_T0.op);
        end
        #2;
        clear = 1'b1;
        #1;
        checkCount++;
        if (obs !== E_IDLE) begin
            errorCount++;
            $display("[TB] FAIL reset_async: got ctrl=%05h, required 00000", obs.ctrl);
        end
        @(posedge Clock); #1;
        clear = 1'b0;
    endtask

    task automatic test_add;
        step_t seq[$];
        IR = 32'h00918000;
        Mem_ready = 1'b1; Stop = 1'b0;
        doReset();
        seq.push_back(st(1'b1, 1'b0, E_T0));
        seq.push_back(st(1'b1, 1'b0, E_T1));
        seq.push_back(st(1'b1, 1'b0, E_T2));
        seq.push_back(st(1'b1, 1'b0, mk(M_YIN | M_RUN, 16'h0004, 16'h0, 4'h0)));
        seq.push_back(st(1'b1, 1'b0, mk(M_ZINL | M_ZINH | M_RUN, 16'h0008, 16'h0, 4'b0000)));
        seq.push_back(st(1'b1, 1'b0, mk(M_ZLOWOUT | M_RUN, 16'h0, 16'h0002, 4'h0)));
        seq.push_back(st(1'b1, 1'b0, E_T0));
        for (int i = 0; i < seq.size(); i++) begin
            Mem_ready = seq[i].ready; Stop = seq[i].stop;
            #1;
            checkCount++;
            if (obs !== seq[i].e) begin
                errorCount++;
                $display("[TB] FAIL add step %0d: got ctrl=%05h rout=%04h rin=%04h op=%h, required ctrl=%05h rout=%04h rin=%04h op=%h",
                         i, obs.ctrl, obs.rout, obs.rin, obs.op, seq[i].e.ctrl, seq[i].e.rout, seq[i].e.rin, seq[i].e.op);
            end
            @(posedge Clock); #1;
        end
    endtask

    task automatic test_mem_wait;
        step_t seq[$];
        int readCnt, pcinCnt, mdrinCnt;
        readCnt = 0; pcinCnt = 0; mdrinCnt = 0;
        IR = 32'h00918000;
        Mem_ready = 1'b1; Stop = 1'b0;
        doReset();
        seq.push_back(st(1'b0, 1'b0, E_T0));
        seq.push_back(st(1'b0, 1'b0, E_T1W));
        seq.push_back(st(1'b0, 1'b0, E_T1W));
        seq.push_back(st(1'b0, 1'b0, E_T1W));
        seq.push_back(st(1'b1, 1'b0, E_T1));
        seq.push_back(st(1'b1, 1'b0, E_T2));
        seq.push_back(st(1'b1, 1'b0, mk(M_YIN | M_RUN, 16'h0004, 16'h0, 4'h0)));
        for (int i = 0; i < seq.size(); i++) begin
            Mem_ready = seq[i].ready; Stop = seq[i].stop;
            #1;
            readCnt  += int'(Read);
            pcinCnt  += int'(PCin);
            mdrinCnt += int'(MDRin);
            checkCount++;
            if (obs !== seq[i].e) begin
                errorCount++;
                $display("[TB] FAIL memwait step %0d: got ctrl=%05h rout=%04h rin=%04h op=%h, required ctrl=%05h rout=%04h rin=%04h op=%h",
                         i, obs.ctrl, obs.rout, obs.rin, obs.op, seq[i].e.ctrl, seq[i].e.rout, seq[i].e.rin, seq[i].e.op);
            end
            @(posedge Clock); #1;
        end
        checkCount++;
        if (readCnt != 4) begin
            errorCount++;
            $display("[TB] FAIL memwait_read_cycles: got %0d, required 4", readCnt);
        end
        checkCount++;
        if (pcinCnt != 1) begin
            errorCount++;
            $display("[TB] FAIL memwait_pcin_cycles: got %0d, required 1", pcinCnt);
        end
        checkCount++;
        if (mdrinCnt != 4) begin
            errorCount++;
            $display("[TB] FAIL memwait_mdrin_cycles: got %0d, required 4", mdrinCnt);
        end
    endtask

    task automatic test_mul;
        step_t seq[$];
        IR = 32'h43380000;
        Mem_ready = 1'b1; Stop = 1'b0;
        doReset();
        seq.push_back(st(1'b1, 1'b0, E_T0));
        seq.push_back(st(1'b1, 1'b0, E_T1));
        seq.push_back(st(1'b1, 1'b0, E_T2));
        seq.push_back(st(1'b1, 1'b0, mk(M_YIN | M_RUN, 16'h0040, 16'h0, 4'h0)));
        seq.push_back(st(1'b1, 1'b0, mk(M_ZINL | M_ZINH | M_RUN, 16'h0080, 16'h0, 4'b0010)));
        seq.push_back(st(1'b1, 1'b0, mk(M_ZLOWOUT | M_LOIN | M_RUN, 16'h0, 16'h0, 4'h0)));
        seq.push_back(st(1'b1, 1'b0, mk(M_ZHIGHOUT | M_HIIN | M_RUN, 16'h0, 16'h0, 4'h0)));
        seq.push_back(st(1'b1, 1'b0, E_T0));
        for (int i = 0; i < seq.size(); i++) begin
            Mem_ready = seq[i].ready; Stop = seq[i].stop;
            #1;
            checkCount++;
            if (obs !== seq[i].e) begin
                errorCount++;
                $display("[TB] FAIL mul step %0d: got ctrl=%05h rout=%04h rin=%04h op=%h, required ctrl=%05h rout=%04h rin=%04h op=%h",
                         i, obs.ctrl, obs.rout, obs.rin, obs.op, seq[i].e.ctrl, seq[i].e.rout, seq[i].e.rin, seq[i].e.op);
            end
            @(posedge Clock); #1;
        end
    endtask

    task automatic test_unary;
        step_t seq[$];
        IR = 32'h52280000;
        Mem_ready = 1'b1; Stop = 1'b0;
        doReset();
        seq.push_back(st(1'b1, 1'b0, E_T0));
        seq.push_back(st(1'b1, 1'b0, E_T1));
        seq.push_back(st(1'b1, 1'b0, E_T2));
        seq.push_back(st(1'b1, 1'b0, E_RUN));
        seq.push_back(st(1'b1, 1'b0, mk(M_ZINL | M_RUN, 16'h0020, 16'h0, 4'b1010)));
        seq.push_back(st(1'b1, 1'b0, mk(M_ZLOWOUT | M_RUN, 16'h0, 16'h0010, 4'h0)));
        seq.push_back(st(1'b1, 1'b0, E_T0));
        for (int i = 0; i < seq.size(); i++) begin
            Mem_ready = seq[i].ready; Stop = seq[i].stop;
            #1;
            checkCount++;
            if (obs !== seq[i].e) begin
                errorCount++;
                $display("[TB] FAIL neg step %0d: got ctrl=%05h rout=%04h rin=%04h op=%h, required ctrl=%05h rout=%04h rin=%04h op=%h",
                         i, obs.ctrl, obs.rout, obs.rin, obs.op, seq[i].e.ctrl, seq[i].e.rout, seq[i].e.rin, seq[i].e.op);
            end
            @(posedge Clock); #1;
        end
    endtask

    task automatic test_illegal;
        step_t seq[$];
        int illegalCnt;
        illegalCnt = 0;
        IR = 32'hF8000000;
        Mem_ready = 1'b1; Stop = 1'b0;
        doReset();
        seq.push_back(st(1'b1, 1'b0, E_T0));
        seq.push_back(st(1'b1, 1'b0, E_T1));
        seq.push_back(st(1'b1, 1'b0, E_T2));
        seq.push_back(st(1'b1, 1'b0, mk(M_ILLEGAL | M_RUN, 16'h0, 16'h0, 4'h0)));
        seq.push_back(st(1'b1, 1'b0, E_RUN));
        seq.push_back(st(1'b1, 1'b0, E_T0));
        for (int i = 0; i < seq.size(); i++) begin
            Mem_ready = seq[i].ready; Stop = seq[i].stop;
            #1;
            illegalCnt += int'(Illegal);
            checkCount++;
            if (obs !== seq[i].e) begin
                errorCount++;
                $display("[TB] FAIL illegal step %0d: got ctrl=%05h rout=%04h rin=%04h op=%h, required ctrl=%05h rout=%04h rin=%04h op=%h",
                         i, obs.ctrl, obs.rout, obs.rin, obs.op, seq[i].e.ctrl, seq[i].e.rout, seq[i].e.rin, seq[i].e.op);
            end
            @(posedge Clock); #1;
        end
        checkCount++;
        if (illegalCnt != 1) begin
            errorCount++;
            $display("[TB] FAIL illegal_pulse_cycles: got %0d, required 1", illegalCnt);
        end
    endtask

    task automatic test_halt;
        step_t seq[$];
        int busyCycles;
        busyCycles = 0;
        IR = 32'hC8000000;
        Mem_ready = 1'b1; Stop = 1'b0;
        doReset();
        seq.push_back(st(1'b1, 1'b0, E_T0));
        seq.push_back(st(1'b1, 1'b0, E_T1));
        seq.push_back(st(1'b1, 1'b0, E_T2));
        seq.push_back(st(1'b1, 1'b0, E_RUN));
        seq.push_back(st(1'b1, 1'b0, E_IDLE));
        for (int i = 0; i < seq.size(); i++) begin
            Mem_ready = seq[i].ready; Stop = seq[i].stop;
            #1;
            checkCount++;
            if (obs !== seq[i].e) begin
                errorCount++;
                $display("[TB] FAIL halt step %0d: got ctrl=%05h rout=%04h rin=%04h op=%h, required ctrl=%05h rout=%04h rin=%04h op=%h",
                         i, obs.ctrl, obs.rout, obs.rin, obs.op, seq[i].e.ctrl, seq[i].e.rout, seq[i].e.rin, seq[i].e.op);
            end
            @(posedge Clock); #1;
        end
        for (int i = 0; i < 20; i++) begin
            Stop = i[0];
            #1;
            if (obs !== E_IDLE) busyCycles++;
            @(posedge Clock); #1;
        end
        Stop = 1'b0;
        checkCount++;
        if (busyCycles != 0) begin
            errorCount++;
            $display("[TB] FAIL halt_sticky: got %0d active cycles, required 0", busyCycles);
        end
        clear = 1'b1;
        @(posedge Clock); #1;
        clear = 1'b0;
        #1;
        checkCount++;
        if (obs !== E_IDLE) begin
            errorCount++;
            $display("[TB] FAIL halt_restart_rst: got ctrl=%05h, required 00000", obs.ctrl);
        end
        @(posedge Clock); #1;
        checkCount++;
        if (obs !== E_T0) begin
            errorCount++;
            $display("[TB] FAIL halt_restart_t0: got ctrl=%05h, required %05h", obs.ctrl, E_T0.ctrl);
        end
    endtask

    task automatic test_clear_mid;
        exp_t addT4;
        addT4 = mk(M_ZINL | M_ZINH | M_RUN, 16'h0008, 16'h0, 4'b0000);
        IR = 32'h00918000;
        Mem_ready = 1'b1; Stop = 1'b0;
        doReset();
        repeat (4) begin
            @(posedge Clock); #1;
        end
        checkCount++;
        if (obs !== addT4) begin
            errorCount++;
            $display("[TB] FAIL clearmid_t4: got ctrl=%05h rout=%04h, required ctrl=%05h rout=0008", obs.ctrl, obs.rout, addT4.ctrl);
        end
        #2;
        clear = 1'b1;
        #1;
        checkCount++;
        if (obs !== E_IDLE) begin
            errorCount++;
            $display("[TB] FAIL clearmid_same_cycle: got ctrl=%05h rout=%04h, required all zero", obs.ctrl, obs.rout);
        end
        @(posedge Clock); #1;
        checkCount++;
        if (obs !== E_IDLE) begin
            errorCount++;
            $display("[TB] FAIL clearmid_no_rin: got ctrl=%05h rin=%04h, required all zero", obs.ctrl, obs.rin);
        end
        clear = 1'b0;
        @(posedge Clock); #1;
        checkCount++;
        if (obs !== E_T0) begin
            errorCount++;
            $display("[TB] FAIL clearmid_restart: got ctrl=%05h, required %05h", obs.ctrl, E_T0.ctrl);
        end
    endtask

    task automatic test_stop;
        step_t seq[$];
        IR = 32'h11230000;
        Mem_ready = 1'b1; Stop = 1'b0;
        doReset();
        seq.push_back(st(1'b1, 1'b0, E_T0));
        seq.push_back(st(1'b1, 1'b0, E_T1));
        seq.push_back(st(1'b1, 1'b0, E_T2));
        seq.push_back(st(1'b1, 1'b1, mk(M_YIN | M_RUN, 16'h0010, 16'h0, 4'h0)));
        seq.push_back(st(1'b1, 1'b0, mk(M_ZINL | M_ZINH | M_RUN, 16'h0040, 16'h0, 4'b0100)));
        seq.push_back(st(1'b1, 1'b1, mk(M_ZLOWOUT | M_RUN, 16'h0, 16'h0004, 4'h0)));
        seq.push_back(st(1'b1, 1'b1, E_IDLE));
        seq.push_back(st(1'b1, 1'b0, E_IDLE));
        seq.push_back(st(1'b1, 1'b0, E_T0));
        for (int i = 0; i < seq.size(); i++) begin
            Mem_ready = seq[i].ready; Stop = seq[i].stop;
            #1;
            checkCount++;
            if (obs !== seq[i].e) begin
                errorCount++;
                $display("[TB] FAIL stop_and step %0d: got ctrl=%05h rout=%04h rin=%04h op=%h, required ctrl=%05h rout=%04h rin=%04h op=%h",
                         i, obs.ctrl, obs.rout, obs.rin, obs.op, seq[i].e.ctrl, seq[i].e.rout, seq[i].e.rin, seq[i].e.op);
            end
            @(posedge Clock); #1;
        end
    endtask

    task automatic test_nop_stop;
        step_t seq[$];
        IR = 32'hC0000000;
        Mem_ready = 1'b1; Stop = 1'b0;
        doReset();
        seq.push_back(st(1'b1, 1'b0, E_T0));
        seq.push_back(st(1'b1, 1'b0, E_T1));
        seq.push_back(st(1'b1, 1'b0, E_T2));
        seq.push_back(st(1'b1, 1'b0, E_RUN));
        seq.push_back(st(1'b1, 1'b1, E_RUN));
        seq.push_back(st(1'b1, 1'b0, E_IDLE));
        seq.push_back(st(1'b1, 1'b0, E_T0));
        for (int i = 0; i < seq.size(); i++) begin
            Mem_ready = seq[i].ready; Stop = seq[i].stop;
            #1;
            checkCount++;
            if (obs !== seq[i].e) begin
                errorCount++;
                $display("[TB] FAIL nop_stop step %0d: got ctrl=%05h rout=%04h rin=%04h op=%h, required ctrl=%05h rout=%04h rin=%04h op=%h",
                         i, obs.ctrl, obs.rout, obs.rin, obs.op, seq[i].e.ctrl, seq[i].e.rout, seq[i].e.rin, seq[i].e.op);
            end
            @(posedge Clock); #1;
        end
    endtask

    // Scenario sequence followed by the single summary line.
    initial begin
        clear = 1'b1;
        IR = 32'h0;
        Mem_ready = 1'b1;
        Stop = 1'b0;
        test_reset();
        test_add();
        test_mem_wait();
        test_mul();
        test_unary();
        test_illegal();
        test_halt();
        test_clear_mid();
        test_stop();
        test_nop_stop();
        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

    // Guard against a run that never reaches the summary.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete, got timeout, required finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
